// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite scanline compositor with clear-on-read display port.
// Optional z-priority compositing: define SPRITE_Z_PRIORITY_EN.
module sprite_line_buffer #(
  parameter int LINE_W  = 640,
  parameter int ENTRY_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scanline_start,
  input  logic               line_load,
  input  logic [9:0]         line_addr,
  input  logic [1:0]         line_z,
  input  logic [3:0]         line_palette,
  input  logic               hFlip,
  input  logic               tile_table,
  input  logic [3:0]         tile_x,
  input  logic [3:0]         tile_y_total,
  input  logic [2:0]         tile_y_offset,
  input  logic [2:0]         sizeX,
  input  logic [2:0]         first,
  input  logic [2:0]         last,
  output logic               line_busy,
  output logic [11:0]        tile_addr,
  input  logic [31:0]        tile_data,
  input  logic [9:0]         pix_x,
  output logic [ENTRY_W-1:0] pix_out
);

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_PIX, S_DRAIN
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic [11:0]          r_tile_addr;
  logic [ENTRY_W-1:0]   r_pix_out;
  logic                 r_front;
  logic [2:0]           r_col;
  logic [2:0]           r_pix;
  logic [31:0]          r_row;
  logic [9:0]           r_addr;
  logic [1:0]           r_z;
  logic [3:0]           r_pal;
  logic                 r_hflip;
  logic                 r_tt;
  logic [3:0]           r_tx;
  logic [3:0]           r_ty;
  logic [2:0]           r_toff;
  logic [2:0]           r_sx;
  logic [2:0]           r_last;
  logic                 r_pend_vld;
  logic [10:0]          r_pend_addr;
  logic [ENTRY_W-1:0]   r_pend_new;
  logic [ENTRY_W-1:0]   r_pend_old;
  logic [ENTRY_W-1:0]   r_ram [0:2047];

  logic [31:0]          w_row;
  logic [2:0]           w_src;
  logic [3:0]           w_idx;
  logic [10:0]          w_x;
  logic                 w_in_range;
  logic [10:0]          w_back_addr;
  logic [10:0]          w_front_addr;
  logic [ENTRY_W-1:0]   w_back_rd;
  logic [ENTRY_W-1:0]   w_front_rd;
  logic                 w_win;
  logic                 w_we;

  // Tile column after optional mirroring across the sprite width.
  function automatic logic [3:0] f_tcol(
    input logic       hf,
    input logic [2:0] sx,
    input logic [3:0] tx,
    input logic [2:0] c
  );
    logic [2:0] tc;
    tc = hf ? 3'(sx - c) : c;
    return tx + {1'b0, tc};
  endfunction

  // Pixel source, screen position and RAM ports.
  always_comb begin
    w_row        = (r_pix == 3'd0) ? tile_data : r_row;
    w_src        = r_hflip ? 3'd7 - r_pix : r_pix;
    w_idx        = w_row[{w_src, 2'b00} +: 4];
    w_x          = {1'b0, r_addr} + {5'd0, r_col, 3'd0}
                 + {8'd0, r_pix};
    w_in_range   = w_x < 11'(LINE_W);
    w_back_addr  = {~r_front, w_x[9:0]};
    w_front_addr = {r_front, pix_x};
    w_back_rd    = r_ram[w_back_addr];
    w_front_rd   = r_ram[w_front_addr];
  end

  // Decide whether the pending pixel may replace the stored entry.
  always_comb begin
`ifdef SPRITE_Z_PRIORITY_EN
    w_win = (r_pend_old[3:0] == 4'd0) ||
            (r_pend_new[9:8] > r_pend_old[9:8]);
`else
    w_win = (r_pend_old[3:0] == 4'd0);
`endif
    w_we  = r_pend_vld && w_win && !scanline_start;
  end

  // Scanline RAM: front clears on read, back takes composited pixels.
  always_ff @(posedge clk) begin
    r_ram[w_front_addr] <= '0;
    if (w_we)
      r_ram[r_pend_addr] <= r_pend_new;
  end

  // Fill FSM, buffer swap and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_tile_addr <= '0;
      r_pix_out   <= '0;
      r_front     <= 1'b0;
      r_col       <= '0;
      r_pix       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_z         <= '0;
      r_pal       <= '0;
      r_hflip     <= 1'b0;
      r_tt        <= 1'b0;
      r_tx        <= '0;
      r_ty        <= '0;
      r_toff      <= '0;
      r_sx        <= '0;
      r_last      <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_new  <= '0;
      r_pend_old  <= '0;
    end else begin
      r_pix_out  <= w_front_rd;
      r_pend_vld <= 1'b0;
      if (scanline_start) begin
        r_front <= ~r_front;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (line_load) begin
              r_addr  <= line_addr;
              r_z     <= line_z;
              r_pal   <= line_palette;
              r_hflip <= hFlip;
              r_tt    <= tile_table;
              r_tx    <= tile_x;
              r_ty    <= tile_y_total;
              r_toff  <= tile_y_offset;
              r_sx    <= sizeX;
              r_last  <= last;
              r_col   <= first;
              r_pix   <= 3'd0;
              r_busy  <= 1'b1;
              if (first > last) begin
                r_state <= S_DRAIN;
              end else begin
                r_state     <= S_FETCH;
                r_tile_addr <= {tile_table, tile_y_total,
                  f_tcol(hFlip, sizeX, tile_x, first),
                  tile_y_offset};
              end
            end
          end
          S_FETCH: begin
            r_state <= S_PIX;
            r_pix   <= 3'd0;
          end
          S_PIX: begin
            if (r_pix == 3'd0)
              r_row <= tile_data;
            r_pend_vld  <= (w_idx != 4'd0) && w_in_range;
            r_pend_addr <= w_back_addr;
            r_pend_new  <= {r_z, r_pal, w_idx};
            r_pend_old  <= w_back_rd;
            r_pix       <= r_pix + 3'd1;
            if (r_pix == 3'd7) begin
              if (r_col == r_last) begin
                r_state <= S_DRAIN;
              end else begin
                r_col       <= r_col + 3'd1;
                r_state     <= S_FETCH;
                r_tile_addr <= {r_tt, r_ty,
                  f_tcol(r_hflip, r_sx, r_tx, r_col + 3'd1),
                  r_toff};
              end
            end
          end
          S_DRAIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign line_busy = r_busy;
  assign tile_addr = r_tile_addr;
  assign pix_out   = r_pix_out;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer with a scanline scoreboard.
// Expected compositing follows SPRITE_Z_PRIORITY_EN when defined.
module tb_sprite_line_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scanline_start = 1'b0;
  logic        line_load = 1'b0;
  logic [9:0]  line_addr = '0;
  logic [1:0]  line_z = '0;
  logic [3:0]  line_palette = '0;
  logic        hFlip = 1'b0;
  logic        tile_table = 1'b0;
  logic [3:0]  tile_x = '0;
  logic [3:0]  tile_y_total = '0;
  logic [2:0]  tile_y_offset = '0;
  logic [2:0]  sizeX = '0;
  logic [2:0]  first = '0;
  logic [2:0]  last = '0;
  logic        line_busy;
  logic [11:0] tile_addr;
  logic [31:0] tile_data;
  logic [9:0]  pix_x = 10'd1023;
  logic [9:0]  pix_out;

  logic [31:0] tmem [0:4095];
  logic [9:0]  exp_front [0:1023];
  logic [9:0]  exp_back  [0:1023];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign tile_data = tmem[tile_addr];

  sprite_line_buffer dut (
    .clk(clk), .rst(rst),
    .scanline_start(scanline_start),
    .line_load(line_load), .line_addr(line_addr),
    .line_z(line_z), .line_palette(line_palette),
    .hFlip(hFlip), .tile_table(tile_table),
    .tile_x(tile_x), .tile_y_total(tile_y_total),
    .tile_y_offset(tile_y_offset), .sizeX(sizeX),
    .first(first), .last(last),
    .line_busy(line_busy), .tile_addr(tile_addr),
    .tile_data(tile_data), .pix_x(pix_x),
    .pix_out(pix_out)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(
    input logic [9:0] a, input logic [1:0] z,
    input logic [3:0] pal, input logic hf,
    input logic tt, input logic [3:0] tx,
    input logic [3:0] ty, input logic [2:0] toff,
    input logic [2:0] sx, input logic [2:0] f,
    input logic [2:0] l);
    line_addr = a; line_z = z; line_palette = pal;
    hFlip = hf; tile_table = tt; tile_x = tx;
    tile_y_total = ty; tile_y_offset = toff;
    sizeX = sx; first = f; last = l;
  endtask

  // Reference compositing of the current request into exp_back.
  task automatic apply();
    for (int c = int'(first); c <= int'(last); c++) begin
      logic [2:0]  tc;
      logic [3:0]  tcol;
      logic [31:0] row;
      tc   = hFlip ? 3'(sizeX - 3'(c)) : 3'(c);
      tcol = tile_x + {1'b0, tc};
      row  = tmem[{tile_table, tile_y_total, tcol, tile_y_offset}];
      for (int p = 0; p < 8; p++) begin
        int         src;
        int         x;
        logic [3:0] idx;
        logic [9:0] old;
        logic       win;
        src = hFlip ? 7 - p : p;
        idx = row[4*src +: 4];
        x   = int'(line_addr) + 8*c + p;
        if (idx != 4'd0 && x < 640) begin
          old = exp_back[x];
          win = (old[3:0] == 4'd0);
`ifdef SPRITE_Z_PRIORITY_EN
          win = win || (line_z > old[9:8]);
`endif
          if (win) exp_back[x] = {line_z, line_palette, idx};
        end
      end
    end
  endtask

  task automatic model_swap();
    logic [9:0] t;
    for (int i = 0; i < 1024; i++) begin
      t = exp_front[i];
      exp_front[i] = exp_back[i];
      exp_back[i] = t;
    end
  endtask

  task automatic swap();
    @(negedge clk); scanline_start = 1'b1;
    @(negedge clk); scanline_start = 1'b0;
    model_swap();
  endtask

  task automatic load();
    @(negedge clk); line_load = 1'b1;
    @(negedge clk); line_load = 1'b0;
  endtask

  task automatic measure(input string tag, input int exp);
    int n;
    n = 0;
    while (line_busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp);
  endtask

  // Drive pix_x, queue expected entry, compare one cycle later.
  task automatic sweep(input bit chk);
    logic [9:0] eq[$];
    int         aq[$];
    logic [9:0] e;
    int         a;
    for (int x = 0; x < 1025; x++) begin
      @(negedge clk);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        a = aq.pop_front();
        if (chk) check($sformatf("pix%0d", a), pix_out, e);
      end
      if (x < 1024) begin
        pix_x = 10'(x);
        eq.push_back(exp_front[x]);
        aq.push_back(x);
        exp_front[x] = '0;
      end
    end
    pix_x = 10'd1023;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) tmem[i] = '0;
    for (int i = 0; i < 1024; i++) begin
      exp_front[i] = '0;
      exp_back[i] = '0;
    end
    tmem[{1'b0, 4'd2, 4'd3, 3'd5}] = 32'h87654321;
    tmem[{1'b1, 4'd2, 4'd4, 3'd5}] = 32'h87654321;
    tmem[{1'b1, 4'd2, 4'd3, 3'd5}] = 32'h33333333;
    tmem[{1'b0, 4'd1, 4'd6, 3'd0}] = 32'h76543217;
    tmem[{1'b0, 4'd1, 4'd7, 3'd0}] = 32'h0F0F0F0F;
    tmem[{1'b0, 4'd3, 4'd0, 3'd1}] = 32'h99999999;
    tmem[{1'b0, 4'd3, 4'd1, 3'd1}] = 32'hAAAAAAAA;
    tmem[{1'b0, 4'd3, 4'd2, 3'd1}] = 32'h55555555;

    repeat (3) @(negedge clk);
    check("rst_busy", line_busy, 0);
    check("rst_tile_addr", tile_addr, 0);
    check("rst_pix_out", pix_out, 0);
    rst = 1'b0;

    sweep(1'b0);
    swap();
    sweep(1'b0);

    set_slice(10'd16, 2'd2, 4'd5, 1'b0, 1'b0, 4'd3,
              4'd2, 3'd5, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    scanline_start = 1'b1;
    line_load = 1'b1;
    @(negedge clk);
    scanline_start = 1'b0;
    line_load = 1'b0;
    check("ss_over_load", line_busy, 0);
    model_swap();

    apply();
    load();
    check("t1_tile_addr", tile_addr, {1'b0, 4'd2, 4'd3, 3'd5});
    measure("t1_busy", 10);
    swap();
    sweep(1'b1);

    set_slice(10'd16, 2'd1, 4'd7, 1'b1, 1'b1, 4'd3,
              4'd2, 3'd5, 3'd1, 3'd0, 3'd0);
    apply();
    load();
    check("t2_tile_addr", tile_addr, {1'b1, 4'd2, 4'd4, 3'd5});
    measure("t2_busy", 10);
    swap();
    sweep(1'b1);

    set_slice(10'd100, 2'd1, 4'd2, 1'b0, 1'b0, 4'd6,
              4'd1, 3'd0, 3'd0, 3'd0, 3'd0);
    apply();
    load();
    @(negedge clk);
    set_slice(10'd300, 2'd3, 4'd1, 1'b0, 1'b0, 4'd6,
              4'd1, 3'd0, 3'd0, 3'd0, 3'd0);
    line_load = 1'b1;
    @(negedge clk);
    line_load = 1'b0;
    measure("t3a_busy_rest", 8);
    set_slice(10'd100, 2'd3, 4'd9, 1'b0, 1'b0, 4'd7,
              4'd1, 3'd0, 3'd0, 3'd0, 3'd0);
    apply();
    load();
    measure("t3b_busy", 10);
    swap();
    sweep(1'b1);

    set_slice(10'd636, 2'd2, 4'd3, 1'b0, 1'b0, 4'd0,
              4'd3, 3'd1, 3'd1, 3'd0, 3'd1);
    apply();
    load();
    measure("t4_busy", 19);
    set_slice(10'd50, 2'd2, 4'd3, 1'b0, 1'b0, 4'd0,
              4'd3, 3'd1, 3'd1, 3'd2, 3'd1);
    load();
    measure("empty_busy", 1);
    swap();
    sweep(1'b1);

    set_slice(10'd400, 2'd2, 4'd5, 1'b0, 1'b0, 4'd3,
              4'd2, 3'd5, 3'd0, 3'd0, 3'd0);
    apply();
    load();
    measure("t5p_busy", 10);
    set_slice(10'd200, 2'd1, 4'd4, 1'b0, 1'b0, 4'd0,
              4'd3, 3'd1, 3'd2, 3'd0, 3'd2);
    load();
    @(negedge clk);
    @(negedge clk);
    scanline_start = 1'b1;
    @(negedge clk);
    scanline_start = 1'b0;
    check("t5_abort_busy", line_busy, 0);
    model_swap();
    sweep(1'b1);
    set_slice(10'd500, 2'd2, 4'd5, 1'b0, 1'b0, 4'd3,
              4'd2, 3'd5, 3'd0, 3'd0, 3'd0);
    apply();
    load();
    measure("t5d_busy", 10);
    swap();
    sweep(1'b1);

    set_slice(10'd16, 2'd2, 4'd5, 1'b0, 1'b0, 4'd3,
              4'd2, 3'd5, 3'd0, 3'd0, 3'd0);
    apply();
    load();
    measure("t6_busy", 10);
    swap();
    sweep(1'b1);
    sweep(1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
